axi_read_burst_engine: RTL and testbench

AXI_READ_BURST_ENGINE -- requirements
Module: axi_read_burst_engine

---
 rtl/axi_read_burst_engine.sv | 140 ++++++++++++++
 tb/tb_axi_read_burst_engine.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_burst_engine.sv
// AXI4 read burst engine: one request is split into bursts by an external transfer controller, and the read data is streamed out.
// Optional: define AXI_READ_BURST_ENGINE_ERR_CHECK_EN to add a sticky error output for RRESP/RLAST faults.
module axi_read_burst_engine #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int LEN_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AXI_ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]      req_len,
    output logic [AXI_ADDR_W-1:0] ctrl_address,
    output logic [LEN_W-1:0]      ctrl_length,
    output logic                  ctrl_transfer_start,
    output logic                  ctrl_burst_start,
    input  logic [AXI_ADDR_W-1:0] ctrl_axaddr,
    input  logic [7:0]            ctrl_axlen,
    input  logic                  ctrl_last_transfer,
    output logic [AXI_ADDR_W-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [AXI_DATA_W-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [AXI_DATA_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
`ifdef AXI_READ_BURST_ENGINE_ERR_CHECK_EN
    output logic                  error,
`endif
    output logic                  done,
    output logic                  busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] ADDR  = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [2:0] ARSIZE = 3'($clog2(AXI_DATA_W / 8));

    logic [2:0] state;
    logic [7:0] beat_cnt;
    logic [7:0] beat_target;
    logic       last_burst;
    logic       req_fire;
    logic       ar_fire;
    logic       beat;
    logic       final_beat_of_burst;

    assign req_fire            = req_valid && (state == IDLE);
    assign ar_fire             = (state == ADDR) && m_arready;
    assign beat                = (state == DATA) && m_rvalid && out_ready;
    assign final_beat_of_burst = (beat_cnt == beat_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ctrl_address <= '0;
            ctrl_length  <= '0;
            beat_cnt     <= '0;
            beat_target  <= '0;
            last_burst   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        if (req_len != '0) begin
                            ctrl_address <= req_addr;
                            ctrl_length  <= req_len;
                            state        <= START;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                START: state <= ADDR;
                ADDR: begin
                    if (m_arready) begin
                        beat_target <= ctrl_axlen;
                        last_burst  <= ctrl_last_transfer;
                        beat_cnt    <= '0;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    // Burst length comes from the latched ARLEN; RLAST is never consulted here.
                    if (beat) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (final_beat_of_burst) begin
                            state <= last_burst ? DONE : ADDR;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready           = (state == IDLE);
    assign ctrl_transfer_start = (state == START);
    assign ctrl_burst_start    = ar_fire;
    assign m_arvalid           = (state == ADDR);
    assign m_araddr            = ctrl_axaddr;
    assign m_arlen             = ctrl_axlen;
    assign m_arsize            = ARSIZE;
    assign m_arburst           = 2'b01;
    assign m_rready            = (state == DATA) && out_ready;
    assign out_valid           = (state == DATA) && m_rvalid;
    assign out_data            = m_rdata;
    assign out_last            = (state == DATA) && last_burst && final_beat_of_burst;
    assign done                = (state == DONE);
    assign busy                = (state != IDLE);

`ifdef AXI_READ_BURST_ENGINE_ERR_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error <= 1'b0;
        end else if (req_fire) begin
            error <= 1'b0;
        end else if (beat && ((m_rresp != 2'b00) || (m_rlast != final_beat_of_burst))) begin
            error <= 1'b1;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{m_rresp, m_rlast};
`endif

endmodule

// File: tb/tb_axi_read_burst_engine.sv
// Self-checking bench for axi_read_burst_engine: a behavioural transfer controller, AXI slave and
// reference burst list (4 KB boundary / 256-beat split) check every AR, beat and done.
module tb_axi_read_burst_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_len = '0;
    logic [31:0] ctrl_address;
    logic [31:0] ctrl_length;
    logic        ctrl_transfer_start;
    logic        ctrl_burst_start;
    logic [31:0] ctrl_axaddr;
    logic [7:0]  ctrl_axlen;
    logic        ctrl_last_transfer;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rlast = 1'b0;
    logic        m_rvalid = 1'b0;
    logic        m_rready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
`ifdef AXI_READ_BURST_ENGINE_ERR_CHECK_EN
    logic        error;
`endif
    logic        done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_read_burst_engine #(
        .AXI_ADDR_W(32),
        .AXI_DATA_W(32),
        .LEN_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .ctrl_address(ctrl_address), .ctrl_length(ctrl_length),
        .ctrl_transfer_start(ctrl_transfer_start), .ctrl_burst_start(ctrl_burst_start),
        .ctrl_axaddr(ctrl_axaddr), .ctrl_axlen(ctrl_axlen), .ctrl_last_transfer(ctrl_last_transfer),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
`ifdef AXI_READ_BURST_ENGINE_ERR_CHECK_EN
        .error(error),
`endif
        .done(done), .busy(busy)
    );

    // Bytes in the next burst: stop at the 4 KB boundary and at 256 beats of 4 bytes.
    function automatic int unsigned burst_bytes(input logic [31:0] a, input logic [31:0] r);
        int unsigned b;
        b = 4096 - (a % 4096);
        if (b > 1024) b = 1024;
        if (r < b) b = r;
        return b;
    endfunction

    // Behavioural transfer controller feeding the engine.
    logic [31:0] cur_addr;
    logic [31:0] cur_rem;
    int unsigned cur_bytes;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr <= '0;
            cur_rem  <= '0;
        end else if (ctrl_transfer_start) begin
            cur_addr <= ctrl_address;
            cur_rem  <= ctrl_length;
        end else if (ctrl_burst_start) begin
            cur_addr <= cur_addr + cur_bytes;
            cur_rem  <= cur_rem - cur_bytes;
        end
    end

    always_comb begin
        cur_bytes          = burst_bytes(cur_addr, cur_rem);
        ctrl_axaddr        = cur_addr;
        ctrl_axlen         = (cur_bytes == 0) ? 8'd0 : 8'((cur_bytes + 3) / 4 - 1);
        ctrl_last_transfer = (cur_rem <= cur_bytes);
    end

    task automatic run_transfer(input logic [31:0] a, input logic [31:0] l, input int mode,
                                input int abort_after, input int bad_beat);
        logic [31:0] ea[$];
        logic [7:0]  el[$];
        logic [31:0] ca;
        logic [31:0] cr;
        int unsigned b;
        int total, ar_idx, pending, beats_seen, last_beat_iter, want_iter;
        bit done_seen;
        logic exp_last;
        ca = a;
        cr = l;
        total = 0;
        while (cr != 0) begin
            b = burst_bytes(ca, cr);
            ea.push_back(ca);
            el.push_back(8'((b + 3) / 4 - 1));
            total += int'((b + 3) / 4);
            ca += b;
            cr -= b;
        end

        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_len = l;
        m_arready = 1'b0; m_rvalid = 1'b0; out_ready = 1'b0; m_rresp = 2'b00; m_rlast = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;

        ar_idx = 0; pending = 0; beats_seen = 0; last_beat_iter = -1; done_seen = 0;
        for (int iter = 0; iter < 6000 && !done_seen; iter++) begin
            if (abort_after > 0 && beats_seen == abort_after) begin
                m_rvalid = 1'b0; out_ready = 1'b1;
                rst = 1'b1;
                #1;
                checks++;
                if ({busy, req_ready, m_rready, done, m_arvalid, out_valid} !== 6'b010000) begin
                    errors++;
                    $display("FAIL abort_state got busy=%b rdy=%b rready=%b done=%b arvalid=%b ovalid=%b want 0 1 0 0 0 0",
                             busy, req_ready, m_rready, done, m_arvalid, out_valid);
                end
                checks++;
                if ({ctrl_address, ctrl_length} !== 64'd0) begin
                    errors++;
                    $display("FAIL abort_ctrl got %h %h want 0 0", ctrl_address, ctrl_length);
                end
                @(negedge clk);
                rst = 1'b0;
                return;
            end

            m_arready = 1'($urandom_range(0, 1));
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (iter % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            m_rvalid = (pending > 0) && (mode != 2 || $urandom_range(0, 3) != 0);
            m_rdata  = $urandom;
            m_rlast  = (pending == 1);
            m_rresp  = (pending > 0 && beats_seen == bad_beat) ? 2'b10 : 2'b00;
            #1;

            if (iter == 0) begin
                checks++;
                if (ctrl_transfer_start !== (l != 0)) begin
                    errors++; $display("FAIL transfer_start got %b want %b", ctrl_transfer_start, (l != 0));
                end
`ifdef AXI_READ_BURST_ENGINE_ERR_CHECK_EN
                checks++;
                if (error !== 1'b0) begin errors++; $display("FAIL error_clear got %b want 0", error); end
`endif
            end
            checks++;
            if ({busy, req_ready} !== 2'b10) begin
                errors++; $display("FAIL busy_rdy got %b%b want 10", busy, req_ready);
            end
            checks++;
            if (pending > 0) begin
                if ({m_rready, out_valid, m_arvalid} !== {out_ready, m_rvalid, 1'b0}) begin
                    errors++;
                    $display("FAIL data_phase got rready=%b ovalid=%b arvalid=%b want %b %b 0",
                             m_rready, out_valid, m_arvalid, out_ready, m_rvalid);
                end
            end else if ({m_rready, out_valid} !== 2'b00) begin
                errors++; $display("FAIL idle_data got rready=%b ovalid=%b want 0 0", m_rready, out_valid);
            end

            if (m_arvalid === 1'b1 && m_arready) begin
                checks++;
                if (ar_idx >= ea.size()) begin
                    errors++; $display("FAIL extra_ar got addr %h want none", m_araddr);
                end else if ({m_araddr, m_arlen, m_arsize, m_arburst, ctrl_burst_start} !==
                             {ea[ar_idx], el[ar_idx], 3'd2, 2'b01, 1'b1}) begin
                    errors++;
                    $display("FAIL ar got %h len %0d size %0d burst %0d bs %b want %h len %0d size 2 burst 1 bs 1",
                             m_araddr, m_arlen, m_arsize, m_arburst, ctrl_burst_start, ea[ar_idx], el[ar_idx]);
                end
                pending = int'(m_arlen) + 1;
                ar_idx++;
            end else begin
                checks++;
                if (ctrl_burst_start !== 1'b0) begin
                    errors++; $display("FAIL burst_start got %b want 0", ctrl_burst_start);
                end
            end

            if (pending > 0 && m_rvalid && out_ready) begin
                exp_last = (ar_idx == ea.size()) && (pending == 1);
                checks++;
                if ({out_data, out_last} !== {m_rdata, exp_last}) begin
                    errors++;
                    $display("FAIL beat%0d got %h last %b want %h last %b", beats_seen, out_data, out_last, m_rdata, exp_last);
                end
                pending--;
                beats_seen++;
                if (beats_seen == total) last_beat_iter = iter;
            end

            if (done === 1'b1) begin
                done_seen = 1;
                want_iter = (total == 0) ? 0 : last_beat_iter + 1;
                checks++;
                if (iter != want_iter || beats_seen != total || ar_idx != ea.size()) begin
                    errors++;
                    $display("FAIL done_timing got cycle %0d beats %0d ars %0d want cycle %0d beats %0d ars %0d",
                             iter, beats_seen, ar_idx, want_iter, total, ea.size());
                end
            end
            @(negedge clk);
        end

        m_rvalid = 1'b0; m_arready = 1'b0;
        #1;
        checks++;
        if (!done_seen) begin
            errors++; $display("FAIL timeout got no done want done");
        end else if ({done, busy, req_ready} !== 3'b001) begin
            errors++; $display("FAIL after_done got done=%b busy=%b rdy=%b want 0 0 1", done, busy, req_ready);
        end
`ifdef AXI_READ_BURST_ENGINE_ERR_CHECK_EN
        checks++;
        if (error !== (bad_beat >= 0 && bad_beat < total)) begin
            errors++; $display("FAIL error_sticky got %b want %b", error, (bad_beat >= 0 && bad_beat < total));
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; m_rvalid = 1'b1; m_arready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, req_ready, done, m_arvalid, m_rready, out_valid, ctrl_transfer_start, ctrl_burst_start} !== 8'b01000000) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b rdy=%b done=%b arv=%b rrdy=%b ov=%b ts=%b bs=%b want 0 1 0 0 0 0 0 0",
                     busy, req_ready, done, m_arvalid, m_rready, out_valid, ctrl_transfer_start, ctrl_burst_start);
        end
        checks++;
        if ({ctrl_address, ctrl_length} !== 64'd0) begin
            errors++; $display("FAIL reset_ctrl got %h %h want 0 0", ctrl_address, ctrl_length);
        end
        @(negedge clk);
        rst = 1'b0; m_rvalid = 1'b0; m_arready = 1'b0;
    endtask

    task automatic test_single_burst();    run_transfer(32'h100, 32'd16, 0, 0, -1); endtask
    task automatic test_boundary_split();  run_transfer(32'hFF8, 32'd16, 0, 0, -1); endtask
    task automatic test_zero_len();        run_transfer(32'h40, 32'd0, 0, 0, -1);   endtask
    task automatic test_ready_toggle();    run_transfer(32'h80, 32'd16, 1, 0, -1);  endtask
    task automatic test_max_burst();       run_transfer(32'h2000, 32'd2048, 0, 0, -1); endtask

    task automatic test_reset_mid_burst();
        run_transfer(32'h200, 32'd16, 0, 2, -1);
        run_transfer(32'h300, 32'd8, 0, 0, -1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) a = 32'($urandom_range(0, 4095)) * 4;
            else a = 32'($urandom_range(1, 7)) * 32'h1000 - 32'($urandom_range(1, 16)) * 4;
            run_transfer(a, 32'($urandom_range(1, 300)) * 4, 2, 0, -1);
        end
    endtask

    task automatic test_back_to_back();
        run_transfer(32'h500, 32'd12, 0, 0, -1);
        run_transfer(32'h0, 32'd0, 0, 0, -1);
        run_transfer(32'h600, 32'd4, 2, 0, -1);
    endtask

`ifdef AXI_READ_BURST_ENGINE_ERR_CHECK_EN
    task automatic test_error();
        run_transfer(32'h700, 32'd16, 0, 0, 1);
        run_transfer(32'h800, 32'd16, 0, 0, -1);
    endtask
`endif

    initial begin
        test_reset();
        test_single_burst();
        test_boundary_split();
        test_zero_len();
        test_ready_toggle();
        test_max_burst();
        test_reset_mid_burst();
        test_random();
        test_back_to_back();
`ifdef AXI_READ_BURST_ENGINE_ERR_CHECK_EN
        test_error();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
